alu_op_scheduler: RTL and testbench
===================================

# alu_op_scheduler

Front-end controller for the shared 32-bit ALU. Arbitrates round-robin between two requesters (port 0 and port 1), drives the ALU's A/B/select inputs stably for an op-dependent settle time (multiply and divide get longer windows), captures the 64-bit result, and returns it on a single response channel tagged with the requester ID. One operation is in flight at a time.

## Interface
Parameters:
- LAT_SIMPLE, 1, settle cycles for add/sub/logic/shift/rotate/negate ops (sel 0,1,5–14)
- LAT_MUL, 3, settle cycles for multiply (sel 2)
- LAT_DIV, 8, settle cycles for divide (sel 4)

Ports:
- clk  in  1  single clock, all state rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  5  ALU select code
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- alu_a, alu_b  out  32  to ALU A/B inputs
- alu_sel  out  5  to ALU select
- alu_out  in  64  ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester ID (0/1)
- rsp_hi, rsp_lo  out  32  alu_out[63:32], alu_out[31:0] as captured
- rsp_err  out  1  illegal op code (3, 15–31)

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: grant one valid requester; reqN_ready is high only for the granted port, only in IDLE, combinational from valid and the RR pointer. Both valid: grant the port not granted last. One valid: grant it. Pointer resets to "last = 1" (port 0 wins the first tie).
- On accept: latch op, a, b, id into internal registers; load the settle counter with the LAT for the op class; go EXEC. Illegal op: no ALU cycle; set err, hi=lo=0, go directly to RESP.
- EXEC: alu_a/alu_b/alu_sel driven from latched registers and held constant. Decrement counter each cycle; at the cycle where counter==1, capture alu_out into rsp_hi/rsp_lo on the clock edge and go RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready; then go IDLE and update the RR pointer to the served id. No new accept in the same cycle as the response handshake.
- Outside EXEC: alu_a=alu_b=0, alu_sel=0.
- Width rules: result captured verbatim from the ALU (32-bit ops return hi=0); the scheduler does no arithmetic on data.
- Requester changing operands while not accepted: ignored; only the accept-cycle values are used.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, rsp_valid=0, rsp_id=0, rsp_hi=rsp_lo=0, rsp_err=0, alu_a=alu_b=0, alu_sel=0, counter=0, RR pointer=1. reqN_ready=0 while rst_n low.
- Accept at edge T; EXEC occupies cycles T+1 … T+LAT; rsp_valid rises at cycle T+LAT+1. Simple op: response 2 cycles after accept edge. Mul: 4. Div: 9. Illegal op: rsp_valid at T+1.
- rsp_ready high when rsp_valid rises: handshake that cycle, IDLE next, next accept possible one cycle later → max throughput one simple op per 3 cycles.
- rsp_ready held low: RESP held indefinitely, both req_ready low.
- Reset asserted mid-EXEC or RESP: immediately abort; the in-flight operation is discarded with no response.

## Test plan
- Single simple op: port 0 add a=5 b=7, rsp_ready=1 → rsp_valid 2 cycles after accept, id=0, hi=0, lo=12, err=0; alu_sel=0 held for exactly 1 cycle.
- Multiply latency: port 1 sel=2, a=b=0x0001_0000 → alu_sel=2 held 3 cycles, rsp_valid 4 cycles after accept, hi=0x0000_0001, lo=0, id=1.
- Arbitration: both ports valid continuously with sub ops (port0 9−4, port1 20−1) → grants alternate 0,1,0,1; responses lo=5,19,5,19 with matching ids; no port granted twice in a row while the other is valid.
- Backpressure: add 1+1 with rsp_ready low for 10 cycles → rsp_valid, rsp_lo=2 stable throughout; req0_ready/req1_ready stay 0; after rsp_ready rises, one handshake only.
- Illegal op: port 0 sel=3 → rsp_valid 1 cycle after accept, err=1, hi=lo=0, alu_sel stays 0.
- Reset mid-op: start div (sel 4) then drop rst_n in cycle 4 of EXEC → all outputs at reset values at once; after release no response emitted; next add 2+3 completes normally with lo=5, port 0 winning a tie.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
//   Front-end controller for the shared 32-bit ALU. Round-robin arbitrates
//   between two requesters, holds the ALU A/B/select inputs stable for an
//   op-dependent settle window, captures the 64-bit ALU result and returns it
//   on a single response channel tagged with the requester ID. One operation
//   is in flight at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for port N (0/1)
//   reqN_op, reqN_a, reqN_b    ALU select code and operands for port N
//   alu_a, alu_b, alu_sel      driven to the ALU (zero outside EXEC)
//   alu_out                    64-bit ALU result
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     requester that issued the op
//   rsp_hi, rsp_lo             captured alu_out[63:32] / alu_out[31:0]
//   rsp_err                    illegal select code (3, 15..31)
// -----------------------------------------------------------------------------
module alu_op_scheduler #(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_sel,
    input  logic [63:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;     // id granted most recently
    logic [4:0]         op_q, op_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // settle cycles remaining
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               err_q, err_d;

    logic               gnt0, gnt1, accept;
    logic [4:0]         acc_op;
    logic [31:0]        acc_a, acc_b;

    function automatic logic op_illegal(input logic [4:0] op);
        op_illegal = (op == 5'd3) || (op >= 5'd15);
    endfunction

    function automatic logic [CNT_W-1:0] op_lat(input logic [4:0] op);
        case (op)
            5'd2:    op_lat = CNT_W'(LAT_MUL);
            5'd4:    op_lat = CNT_W'(LAT_DIV);
            default: op_lat = CNT_W'(LAT_SIMPLE);
        endcase
    endfunction

    // Grant is purely combinational from the valids and the RR pointer.
    // Gated by rst_n so neither port sees ready while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign accept     = gnt0 | gnt1;
    assign acc_op     = gnt1 ? req1_op : req0_op;
    assign acc_a      = gnt1 ? req1_a  : req0_a;
    assign acc_b      = gnt1 ? req1_b  : req0_b;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d = gnt1;
                    op_d = acc_op;
                    a_d  = acc_a;
                    b_d  = acc_b;
                    if (op_illegal(acc_op)) begin
                        // Never touches the ALU: answer straight away.
                        err_d   = 1'b1;
                        hi_d    = '0;
                        lo_d    = '0;
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = op_lat(acc_op);
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // <= 1 also covers a zero latency parameter.
                if (cnt_q <= CNT_W'(1)) begin
                    hi_d    = alu_out[63:32];
                    lo_d    = alu_out[31:0];
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    // ALU inputs are only live during the settle window.
    assign alu_a     = (state_q == S_EXEC) ? a_q  : '0;
    assign alu_b     = (state_q == S_EXEC) ? b_q  : '0;
    assign alu_sel   = (state_q == S_EXEC) ? op_q : '0;

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_hi    = hi_q;
    assign rsp_lo    = lo_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_op_scheduler
//   Self-checking bench for alu_op_scheduler. Provides a behavioural ALU,
//   runs directed scenarios and a randomized run checked against a
//   transaction-level model of arbitration, latency and response contents.
// -----------------------------------------------------------------------------
module tb_alu_op_scheduler;

    localparam int LAT_SIMPLE = 1;
    localparam int LAT_MUL    = 3;
    localparam int LAT_DIV    = 8;

    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_sel;
    logic [63:0] alu_out;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_hi, rsp_lo;

    int checks = 0;
    int errors = 0;

    alu_op_scheduler #(
        .LAT_SIMPLE(LAT_SIMPLE), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unknown selects produce a recognisable junk pattern.
    function automatic logic [63:0] alu_fn(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = '0;
        case (s)
            5'd0:  r[31:0] = a + b;
            5'd1:  r[31:0] = a - b;
            5'd2:  r = {32'd0, a} * {32'd0, b};
            5'd4:  r = (b == 32'd0) ? {64{1'b1}} : {a % b, a / b};
            5'd5:  r[31:0] = a & b;
            5'd6:  r[31:0] = a | b;
            5'd7:  r[31:0] = a ^ b;
            5'd8:  r[31:0] = a << b[4:0];
            5'd9:  r[31:0] = a >> b[4:0];
            5'd10: r[31:0] = $unsigned($signed(a) >>> b[4:0]);
            5'd11: r[31:0] = a + 32'd1;
            5'd12: r[31:0] = a - 32'd1;
            5'd13: r[31:0] = ~a;
            5'd14: r[31:0] = 32'd0 - a;
            default: r = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
        return r;
    endfunction

    assign alu_out = alu_fn(alu_sel, alu_a, alu_b);

    function automatic bit is_illegal(input logic [4:0] op);
        return (op == 5'd3) || (op >= 5'd15);
    endfunction

    // Cycles from accept edge until rsp_valid is seen.
    function automatic int rsp_delay(input logic [4:0] op);
        if (is_illegal(op)) return 1;
        if (op == 5'd2)     return LAT_MUL + 1;
        if (op == 5'd4)     return LAT_DIV + 1;
        return LAT_SIMPLE + 1;
    endfunction

    function automatic logic [4:0] rand_op();
        int r, k;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'($urandom_range(15, 31));
        if (r == 1) return 5'd3;
        k = $urandom_range(0, 13);
        return (k <= 2) ? 5'(k) : 5'(k + 1);
    endfunction

    // Drives one request (call at posedge+1), waits for its grant, then waits
    // for rsp_valid. lat counts accept edge -> rsp_valid; hold counts cycles
    // the ALU saw exactly this op's select and operands.
    task automatic send(input int port, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output bit ok, output logic other_rdy, output int lat, output int hold);
        int w;
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        w = 0;
        while ((((port == 0) ? req0_ready : req1_ready) !== 1'b1) && w < 30) begin
            @(posedge clk); #2; w++;
        end
        ok        = (w < 30);
        other_rdy = (port == 0) ? req1_ready : req0_ready;
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        lat  = 1;
        hold = 0;
        while (rsp_valid !== 1'b1 && lat < 30) begin
            if (alu_sel === op && alu_a === a && alu_b === b) hold++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_hi, rsp_lo} !== '0)
            begin errors++; $display("FAIL reset_rsp: got v=%b id=%b err=%b hi=%h lo=%h expected all zero", rsp_valid, rsp_id, rsp_err, rsp_hi, rsp_lo); end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== '0)
            begin errors++; $display("FAIL reset_alu: got a=%h b=%h sel=%h expected zero", alu_a, alu_b, alu_sel); end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00)
            begin errors++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0)
            begin errors++; $display("FAIL reset_idle: rsp_valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_simple();
        bit ok; logic orr; int lat, hold;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        send(0, 5'd0, 32'd5, 32'd7, ok, orr, lat, hold);
        checks++;
        if (!ok) begin errors++; $display("FAIL simple_grant: no grant within bound"); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL simple_latency: got %0d expected 2", lat); end
        checks++;
        if (hold != 1) begin errors++; $display("FAIL simple_hold: got %0d expected 1", hold); end
        checks++;
        if ({rsp_id, rsp_err, rsp_hi, rsp_lo} !== {1'b0, 1'b0, 32'd0, 32'd12})
            begin errors++; $display("FAIL simple_rsp: got id=%b err=%b hi=%h lo=%h expected 0 0 0 c", rsp_id, rsp_err, rsp_hi, rsp_lo); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL simple_drop: rsp_valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_mul();
        bit ok; logic orr; int lat, hold;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        send(1, 5'd2, 32'h0001_0000, 32'h0001_0000, ok, orr, lat, hold);
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL mul_latency: got ok=%0d lat=%0d expected 1 4", ok, lat); end
        checks++;
        if (hold != 3) begin errors++; $display("FAIL mul_hold: got %0d expected 3", hold); end
        checks++;
        if ({rsp_id, rsp_err, rsp_hi, rsp_lo} !== {1'b1, 1'b0, 32'd1, 32'd0})
            begin errors++; $display("FAIL mul_rsp: got id=%b err=%b hi=%h lo=%h expected 1 0 1 0", rsp_id, rsp_err, rsp_hi, rsp_lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int gid[4], gcyc[4], rid[4], rlo[4];
        int ng, nr, both;
        ng = 0; nr = 0; both = 0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 5'd1; req0_a = 32'd9;  req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 5'd1; req1_a = 32'd20; req1_b = 32'd1;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            #1;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) both++;
            if (ng < 4 && (req0_ready === 1'b1 || req1_ready === 1'b1)) begin
                gid[ng] = (req1_ready === 1'b1) ? 1 : 0; gcyc[ng] = c; ng++;
            end
            if (rsp_valid === 1'b1 && nr < 4) begin
                rid[nr] = int'(rsp_id); rlo[nr] = int'(rsp_lo); nr++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (nr != 4 || ng != 4) begin errors++; $display("FAIL arb_count: got grants=%0d rsps=%0d expected 4 4", ng, nr); end
        checks++;
        if (both != 0) begin errors++; $display("FAIL arb_double_grant: got %0d cycles expected 0", both); end
        for (int i = 0; i < 4; i++) begin
            if (i < ng && i < nr) begin
                checks++;
                if (gid[i] != i % 2 || rid[i] != i % 2 || rlo[i] != ((i % 2) ? 19 : 5))
                    begin errors++; $display("FAIL arb_seq%0d: got gnt=%0d id=%0d lo=%0d expected %0d %0d %0d", i, gid[i], rid[i], rlo[i], i % 2, i % 2, (i % 2) ? 19 : 5); end
            end
            if (i > 0 && i < ng) begin
                checks++;
                if (gcyc[i] - gcyc[i-1] != 3)
                    begin errors++; $display("FAIL arb_spacing%0d: got %0d expected 3", i, gcyc[i] - gcyc[i-1]); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit ok; logic orr; int lat, hold, bad;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        send(0, 5'd0, 32'd1, 32'd1, ok, orr, lat, hold);
        checks++;
        if (!ok || lat != 2) begin errors++; $display("FAIL bp_latency: got ok=%0d lat=%0d expected 1 2", ok, lat); end
        req1_valid = 1'b1; req1_op = 5'd0; req1_a = 32'd9; req1_b = 32'd9;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_lo !== 32'd2 || rsp_hi !== 32'd0 || rsp_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b lo=%h id=%b rdy=%b%b expected 1 2 0 00", i, rsp_valid, rsp_lo, rsp_id, req0_ready, req1_ready);
            end
            @(posedge clk); #1;
        end
        req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin
            if (rsp_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_single_handshake: rsp_valid seen %0d extra cycles expected 0", bad); end
    endtask

    task automatic test_illegal();
        bit ok; logic orr; int lat, hold;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        send(0, 5'd3, 32'h1234, 32'h5678, ok, orr, lat, hold);
        checks++;
        if (!ok || lat != 1) begin errors++; $display("FAIL illegal_latency: got ok=%0d lat=%0d expected 1 1", ok, lat); end
        checks++;
        if ({rsp_id, rsp_err, rsp_hi, rsp_lo} !== {1'b0, 1'b1, 32'd0, 32'd0})
            begin errors++; $display("FAIL illegal_rsp: got id=%b err=%b hi=%h lo=%h expected 0 1 0 0", rsp_id, rsp_err, rsp_hi, rsp_lo); end
        checks++;
        if (alu_sel !== 5'd0 || hold != 0) begin errors++; $display("FAIL illegal_alu: got sel=%h hold=%0d expected 0 0", alu_sel, hold); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        bit ok; logic orr; int lat, hold, seen;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 5'd4; req0_a = 32'd100; req0_b = 32'd7;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_div_grant: req0_ready=%b expected 1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (alu_sel !== 5'd4) begin errors++; $display("FAIL rst_div_exec: alu_sel=%h expected 4", alu_sel); end
        #2;
        rst_n = 1'b0; req0_valid = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_err, rsp_hi, rsp_lo, req0_ready, req1_ready} !== '0)
            begin errors++; $display("FAIL rst_abort: got a=%h sel=%h v=%b id=%b err=%b lo=%h rdy=%b%b expected zero", alu_a, alu_sel, rsp_valid, rsp_id, rsp_err, rsp_lo, req0_ready, req1_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0; rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_ghost_rsp: got %0d cycles expected 0", seen); end
        req1_valid = 1'b1; req1_op = 5'd0; req1_a = 32'd10; req1_b = 32'd10;
        send(0, 5'd0, 32'd2, 32'd3, ok, orr, lat, hold);
        req1_valid = 1'b0;
        checks++;
        if (!ok || orr !== 1'b0) begin errors++; $display("FAIL rst_tie: got ok=%0d other_ready=%b expected 1 0", ok, orr); end
        checks++;
        if (lat != 2 || rsp_lo !== 32'd5 || rsp_id !== 1'b0 || rsp_err !== 1'b0)
            begin errors++; $display("FAIL rst_next_op: got lat=%0d lo=%h id=%b err=%b expected 2 5 0 0", lat, rsp_lo, rsp_id, rsp_err); end
        @(posedge clk); #1;
    endtask

    // Transaction-level model: at most one op outstanding; grant rule from the
    // last served id; response appears a fixed number of cycles after accept.
    task automatic test_random();
        logic busy, last, exp_id, exp_err, er0, er1, erv, hs;
        logic [63:0] exp_res;
        int since, exp_lat, served;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy = 1'b0; last = 1'b1; since = 0; exp_lat = 0; served = 0;
        exp_id = 1'b0; exp_err = 1'b0; exp_res = '0;
        for (int c = 0; c < 600; c++) begin
            req0_valid = 1'($urandom_range(0, 1)); req0_op = rand_op();
            req0_a = $urandom(); req0_b = $urandom();
            req1_valid = 1'($urandom_range(0, 1)); req1_op = rand_op();
            req1_a = $urandom(); req1_b = $urandom();
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            er0 = !busy && req0_valid && (!req1_valid || last);
            er1 = !busy && req1_valid && (!req0_valid || !last);
            checks++;
            if ({req0_ready, req1_ready} !== {er0, er1})
                begin errors++; $display("FAIL rand_grant@%0d: got %b%b expected %b%b", c, req0_ready, req1_ready, er0, er1); end
            erv = busy && (since >= exp_lat);
            checks++;
            if (rsp_valid !== erv)
                begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", c, rsp_valid, erv); end
            if (erv) begin
                checks++;
                if ({rsp_id, rsp_err, rsp_hi, rsp_lo} !== {exp_id, exp_err, exp_res})
                    begin errors++; $display("FAIL rand_rsp@%0d: got id=%b err=%b %h_%h expected %b %b %h", c, rsp_id, rsp_err, rsp_hi, rsp_lo, exp_id, exp_err, exp_res); end
            end
            hs = erv && rsp_ready;
            @(posedge clk); #1;
            if (busy) since++;
            if (hs) begin busy = 1'b0; last = exp_id; served++; end
            if (er0 || er1) begin
                busy = 1'b1; since = 1; exp_id = er1;
                if (is_illegal(er1 ? req1_op : req0_op)) begin
                    exp_err = 1'b1; exp_res = '0;
                end else begin
                    exp_err = 1'b0;
                    exp_res = er1 ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
                end
                exp_lat = rsp_delay(er1 ? req1_op : req0_op);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (served < 20) begin errors++; $display("FAIL rand_progress: got %0d responses expected at least 20", served); end
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_simple();
        test_mul();
        test_arbitration();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
